// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle RISC-V control FSM (fetch/decode/exec/mem/wb) with halt and error traps.
// Define CONTADOR_CICLOS_EN to enable the ciclos/retiradas performance counters.
module unidade_controle #(
    parameter int NUM_INSTR = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic [31:0] imm,
    output logic [2:0]  estado,
    output logic [31:0] PC,
    output logic        reg_we,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        erro,
    output logic [31:0] ciclos,
    output logic [31:0] retiradas
);
    localparam logic [2:0] FETCH  = 3'b000;
    localparam logic [2:0] DECODE = 3'b001;
    localparam logic [2:0] EXEC   = 3'b010;
    localparam logic [2:0] MEM    = 3'b011;
    localparam logic [2:0] WB     = 3'b100;
    localparam logic [2:0] HALT   = 3'b101;
    localparam logic [2:0] ERRO   = 3'b110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [2:0]  r_estado;
    logic [31:0] r_pc;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [2:0]  w_next;
    logic        w_valid, w_load, w_store, w_branch, w_taken, w_retire;
    logic [31:0] w_pc_next;

    assign w_valid  = opcode == OP_R || opcode == OP_I || opcode == OP_LOAD ||
                      opcode == OP_STORE || opcode == OP_BRANCH;
    assign w_load   = r_opcode == OP_LOAD;
    assign w_store  = r_opcode == OP_STORE;
    assign w_branch = r_opcode == OP_BRANCH;
    assign w_taken  = w_branch && ((r_funct3 == 3'b000 && zero) || (r_funct3 == 3'b001 && !zero));
    // imm is a byte offset; PC counts words
    assign w_pc_next = w_taken ? r_pc + 32'($signed(imm) >>> 2) : r_pc + 32'd1;

    always_comb begin
        w_next = r_estado;
        case (r_estado)
            FETCH:   w_next = (r_pc >= 32'(NUM_INSTR)) ? HALT : DECODE;
            DECODE:  w_next = w_valid ? EXEC : ERRO;
            EXEC:    w_next = w_branch ? FETCH : (w_load || w_store) ? MEM : WB;
            MEM:     w_next = w_load ? WB : FETCH;
            WB:      w_next = FETCH;
            default: w_next = r_estado;
        endcase
    end

    assign w_retire = r_estado != FETCH && w_next == FETCH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= FETCH;
            r_pc     <= '0;
            r_opcode <= '0;
            r_funct3 <= '0;
        end else begin
            r_estado <= w_next;
            if (w_retire)
                r_pc <= w_pc_next;
            if (r_estado == DECODE) begin
                r_opcode <= opcode;
                r_funct3 <= funct3;
            end
        end
    end

`ifdef CONTADOR_CICLOS_EN
    logic [31:0] r_ciclos, r_retiradas;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ciclos    <= '0;
            r_retiradas <= '0;
        end else begin
            if (r_estado != HALT && r_estado != ERRO)
                r_ciclos <= r_ciclos + 32'd1;
            if (w_retire)
                r_retiradas <= r_retiradas + 32'd1;
        end
    end
    assign ciclos    = r_ciclos;
    assign retiradas = r_retiradas;
`else
    assign ciclos    = '0;
    assign retiradas = '0;
`endif

    assign estado     = r_estado;
    assign PC         = r_pc;
    assign reg_we     = r_estado == WB;
    assign mem_read   = r_estado == MEM && w_load;
    assign mem_write  = r_estado == MEM && w_store;
    assign alu_src    = (r_estado == EXEC || r_estado == MEM || r_estado == WB) &&
                        (r_opcode == OP_I || w_load || w_store);
    assign mem_to_reg = r_estado == WB && w_load;
    assign halted     = r_estado == HALT;
    assign erro       = r_estado == ERRO;
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed-vector bench for unidade_controle with hand-computed expectations.
module tb_unidade_controle;
    logic        clk = 0, reset = 1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        zero = 0;
    logic [31:0] imm = '0;
    logic [2:0]  estado;
    logic [31:0] PC, ciclos, retiradas;
    logic        reg_we, mem_read, mem_write, alu_src, mem_to_reg, halted, erro;
    int          n_chk = 0, n_fail = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011;

    unidade_controle #(.NUM_INSTR(11)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .imm(imm),
        .estado(estado), .PC(PC), .reg_we(reg_we), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .halted(halted), .erro(erro),
        .ciclos(ciclos), .retiradas(retiradas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) step();
        reset = 0;
    endtask

    task automatic run_r();
        opcode = OP_R;
        repeat (4) step();
    endtask

    initial begin
        do_reset();
        chk("rst_estado", 32'(estado), 0);
        chk("rst_pc", PC, 0);
        chk("rst_ctrl", {reg_we, mem_read, mem_write, alu_src, mem_to_reg, halted, erro}, 0);
        chk("rst_ciclos", ciclos, 0);
        chk("rst_ret", retiradas, 0);

        // R-type at PC=0
        opcode = OP_R;
        step(); chk("r_dec", 32'(estado), 1); chk("r_dec_we", 32'(reg_we), 0);
        step(); chk("r_exec", 32'(estado), 2); chk("r_exec_we", 32'(reg_we), 0);
        chk("r_exec_alusrc", 32'(alu_src), 0);
        step(); chk("r_wb", 32'(estado), 4); chk("r_wb_we", 32'(reg_we), 1);
        step(); chk("r_fetch", 32'(estado), 0); chk("r_pc", PC, 1);

        run_r(); chk("r2_pc", PC, 2);

        // load at PC=2
        opcode = OP_LD;
        step(); chk("ld_dec", 32'(estado), 1);
        step(); chk("ld_exec", 32'(estado), 2); chk("ld_exec_alusrc", 32'(alu_src), 1);
        step(); chk("ld_mem", 32'(estado), 3); chk("ld_mem_rd", 32'(mem_read), 1);
        chk("ld_mem_wr", 32'(mem_write), 0); chk("ld_mem_we", 32'(reg_we), 0);
        step(); chk("ld_wb", 32'(estado), 4); chk("ld_wb_m2r", 32'(mem_to_reg), 1);
        chk("ld_wb_we", 32'(reg_we), 1); chk("ld_wb_rd", 32'(mem_read), 0);
        step(); chk("ld_fetch", 32'(estado), 0); chk("ld_pc", PC, 3);

        // I-arith at PC=3
        opcode = OP_I;
        step(); step(); chk("i_exec_alusrc", 32'(alu_src), 1);
        step(); chk("i_wb", 32'(estado), 4); chk("i_wb_m2r", 32'(mem_to_reg), 0);
        step(); chk("i_pc", PC, 4);

        // beq taken, imm=-8 -> -2 words
        opcode = OP_BR; funct3 = 3'b000; zero = 1; imm = -32'sd8;
        step(); chk("beq_dec", 32'(estado), 1);
        step(); chk("beq_exec", 32'(estado), 2); chk("beq_exec_we", 32'(reg_we), 0);
        step(); chk("beq_fetch", 32'(estado), 0); chk("beq_t_pc", PC, 2);

        run_r(); run_r(); chk("r4_pc", PC, 4);
        opcode = OP_BR; funct3 = 3'b000; zero = 0; imm = -32'sd8;
        repeat (3) step(); chk("beq_nt_pc", PC, 5);

        // bne taken with zero=0, imm=16 -> +4 words
        opcode = OP_BR; funct3 = 3'b001; zero = 0; imm = 32'd16;
        repeat (3) step(); chk("bne_t_pc", PC, 9);
        // funct3=100 never taken
        opcode = OP_BR; funct3 = 3'b100; zero = 1; imm = 32'd16;
        repeat (3) step(); chk("br_f3_pc", PC, 10);

        // store at PC=10
        opcode = OP_ST; funct3 = 0; zero = 0; imm = 0;
        step(); step(); chk("st_exec_alusrc", 32'(alu_src), 1);
        step(); chk("st_mem", 32'(estado), 3); chk("st_mem_wr", 32'(mem_write), 1);
        chk("st_mem_rd", 32'(mem_read), 0);
        step(); chk("st_fetch", 32'(estado), 0); chk("st_pc", PC, 11);

        // reset mid-MEM of a store
        do_reset();
        run_r(); chk("pre_st_pc", PC, 1);
        opcode = OP_ST;
        repeat (3) step(); chk("st2_mem_wr", 32'(mem_write), 1);
        #2 reset = 1;
        #1 chk("rst_mid_wr", 32'(mem_write), 0);
        chk("rst_mid_estado", 32'(estado), 0);
        chk("rst_mid_pc", PC, 0);
        chk("rst_mid_ret", retiradas, 0);
        step(); reset = 0;
        opcode = OP_R;
        step(); chk("resume_dec", 32'(estado), 1); chk("resume_pc", PC, 0);

        // unknown opcode -> sticky ERRO
        do_reset();
        opcode = 7'b1111111;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("erro_estado", 32'(estado), 6);
            chk("erro_flag", 32'(erro), 1);
            chk("erro_pc", PC, 0);
            step();
        end
        do_reset();
        chk("erro_rst_estado", 32'(estado), 0);
        chk("erro_rst_flag", 32'(erro), 0);
        chk("erro_rst_pc", PC, 0);

        // straight-line R-types to HALT
        opcode = OP_R;
        begin
            int n = 0;
            while (!halted && n < 100) begin
                step();
                n++;
            end
            chk("halt_timeout", 32'(halted), 1);
            chk("halt_cycles", n, 45);
        end
        chk("halt_estado", 32'(estado), 5);
        chk("halt_pc", PC, 11);
`ifdef CONTADOR_CICLOS_EN
        chk("halt_ret", retiradas, 11);
        chk("halt_ciclos", ciclos, 45);
`else
        chk("halt_ret", retiradas, 0);
        chk("halt_ciclos", ciclos, 0);
`endif
        repeat (5) step();
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_pc_frozen", PC, 11);
`ifdef CONTADOR_CICLOS_EN
        chk("halt_ciclos_frozen", ciclos, 45);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
